// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    VALID  = 2'd2,
    HALTED = 2'd3
  } state_t;

  // Opcode (upper 4 bits of a word) that stops the sequencer.
  localparam logic [3:0] HLT_OP = 4'hF;

  // Built-in program: the leftmost word lives at address 0.
  localparam int DEFAULT_LEN = 7;
  localparam logic [DEFAULT_LEN*8-1:0] DEFAULT_PROG =
    {8'h22, 8'h2D, 8'h38, 8'h17, 8'h31, 8'h07, 8'h43};

  // Word idx of the built-in program, zero beyond its end.
  function automatic logic [7:0] default_word(input int idx);
    if (idx < 0 || idx >= DEFAULT_LEN) return 8'h00;
    return DEFAULT_PROG[(DEFAULT_LEN-1-idx)*8 +: 8];
  endfunction

endpackage

// File: rtl/fetch_sequencer_prog_rom.sv
// Program ROM with a registered read port. Contents come from the
// package program, or from an explicit image when USE_IMAGE is set
// (word i at bits [i*WORD_W +: WORD_W]). Addresses at or beyond
// PROG_LEN read as zero.
module prog_rom
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int WORD_W   = 8,
  parameter int PROG_LEN = 7,
  parameter bit USE_IMAGE = 1'b0,
  parameter logic [WORD_W*(2**ADDR_W)-1:0] PROG_IMAGE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  output logic [WORD_W-1:0] data
);

  localparam int DEPTH = 2**ADDR_W;

  // Contents of one ROM location, resolved at elaboration.
  function automatic logic [WORD_W-1:0] init_word(input int idx);
    if (idx >= PROG_LEN) return '0;
    if (USE_IMAGE) return PROG_IMAGE[idx*WORD_W +: WORD_W];
    return WORD_W'(default_word(idx));
  endfunction

  logic [WORD_W-1:0] mem [DEPTH];

  // Constant ROM contents, one word per location.
  for (genvar i = 0; i < DEPTH; i++) begin : g_init
    assign mem[i] = init_word(i);
  end

  // Registered read; the word is held between reads.
  // NOTE: only the read register is reset; the array is constant and
  // resetting storage would just turn it into a wide register bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
    end else if (rd_en) begin
      data <= mem[addr];
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks the program ROM, presents one word
// at a time on a valid/ready handshake, follows jumps and stops on the
// halt opcode or when the next address leaves the program.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int WORD_W   = 8,
  parameter int PROG_LEN = 7,
  parameter bit USE_IMAGE = 1'b0,
  parameter logic [WORD_W*(2**ADDR_W)-1:0] PROG_IMAGE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              instr_ready,
  output logic [WORD_W-1:0] instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  // One extra bit so PROG_LEN == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] LEN = (ADDR_W+1)'(PROG_LEN);

  state_t            state;
  logic              rd_en;
  logic              accept;
  logic              is_hlt;
  logic              in_range;
  logic [ADDR_W-1:0] next_pc;

  prog_rom #(
    .ADDR_W    (ADDR_W),
    .WORD_W    (WORD_W),
    .PROG_LEN  (PROG_LEN),
    .USE_IMAGE (USE_IMAGE),
    .PROG_IMAGE(PROG_IMAGE)
  ) u_rom (
    .clk  (clk),
    .rst  (rst),
    .rd_en(rd_en),
    .addr (pc),
    .data (instr)
  );

  // Handshake decode and next-address selection.
  // NOTE: every signal gets a value before any condition so no latch
  // can be inferred.
  always_comb begin
    rd_en    = (state == FETCH);
    accept   = (state == VALID) && instr_valid && instr_ready;
    is_hlt   = (instr[WORD_W-1 -: 4] == HLT_OP);
    next_pc  = jump_en ? jump_addr : pc + ADDR_W'(1);
    in_range = ({1'b0, next_pc} < LEN);
  end

  // Sequencer FSM with registered pc, instr_valid and halted.
  // NOTE: non-blocking assignments keep every register sampling the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pc    <= '0;
            state <= FETCH;
          end
        end
        FETCH: begin
          state       <= VALID;
          instr_valid <= 1'b1;
        end
        VALID: begin
          if (accept) begin
            instr_valid <= 1'b0;
            if (is_hlt) begin
              // Halt opcode: keep pc on the halting word, ignore jumps.
              state  <= HALTED;
              halted <= 1'b1;
            end else begin
              pc <= next_pc;
              if (in_range) begin
                state <= FETCH;
              end else begin
                state  <= HALTED;
                halted <= 1'b1;
              end
            end
          end
        end
        HALTED: begin
          if (start) begin
            pc     <= '0;
            halted <= 1'b0;
            state  <= FETCH;
          end
        end
        default: begin
          state       <= IDLE;
          instr_valid <= 1'b0;
          halted      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench: default program, a program with a halt
// opcode at address 2, and a 4-word wrapping configuration.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default configuration.
  logic       d_rst = 1'b1, d_start = 1'b0, d_jump_en = 1'b0, d_ready = 1'b0;
  logic [3:0] d_jump_addr = '0;
  logic [7:0] d_instr;
  logic       d_valid, d_halted;
  logic [3:0] d_pc;

  // Program with F0 at address 2.
  logic       h_rst = 1'b1, h_start = 1'b0, h_jump_en = 1'b0, h_ready = 1'b0;
  logic [3:0] h_jump_addr = '0;
  logic [7:0] h_instr;
  logic       h_valid, h_halted;
  logic [3:0] h_pc;

  // Two-bit address space, full program, no halt opcode.
  logic       w_rst = 1'b1, w_start = 1'b0, w_jump_en = 1'b0, w_ready = 1'b0;
  logic [1:0] w_jump_addr = '0;
  logic [7:0] w_instr;
  logic       w_valid, w_halted;
  logic [1:0] w_pc;

  fetch_sequencer u_def (
    .clk(clk), .rst(d_rst), .start(d_start), .jump_en(d_jump_en),
    .jump_addr(d_jump_addr), .instr_ready(d_ready), .instr(d_instr),
    .instr_valid(d_valid), .pc(d_pc), .halted(d_halted)
  );

  fetch_sequencer #(
    .ADDR_W(4), .WORD_W(8), .PROG_LEN(7), .USE_IMAGE(1'b1),
    .PROG_IMAGE({72'h0, 56'h43_07_31_17_F0_2D_22})
  ) u_hlt (
    .clk(clk), .rst(h_rst), .start(h_start), .jump_en(h_jump_en),
    .jump_addr(h_jump_addr), .instr_ready(h_ready), .instr(h_instr),
    .instr_valid(h_valid), .pc(h_pc), .halted(h_halted)
  );

  fetch_sequencer #(.ADDR_W(2), .WORD_W(8), .PROG_LEN(4)) u_wrap (
    .clk(clk), .rst(w_rst), .start(w_start), .jump_en(w_jump_en),
    .jump_addr(w_jump_addr), .instr_ready(w_ready), .instr(w_instr),
    .instr_valid(w_valid), .pc(w_pc), .halted(w_halted)
  );

  logic [7:0] exp_words [7] = '{8'h22, 8'h2D, 8'h38, 8'h17, 8'h31, 8'h07, 8'h43};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state.
    step();
    step();
    check("rst_pc",     32'(d_pc), 32'(0));
    check("rst_valid",  32'(d_valid), 32'(0));
    check("rst_halted", 32'(d_halted), 32'(0));
    check("rst_instr",  32'(d_instr), 32'(0));
    check("rst_state",  32'(u_def.state), 32'(IDLE));
    d_rst = 1'b0;
    step();
    step();
    check("idle_hold_state", 32'(u_def.state), 32'(IDLE));
    check("idle_hold_valid", 32'(d_valid), 32'(0));

    // Sequential run with ready held high.
    d_start = 1'b1;
    d_ready = 1'b1;
    step();
    d_start = 1'b0;
    check("seq_fetch_state", 32'(u_def.state), 32'(FETCH));
    check("seq_fetch_valid", 32'(d_valid), 32'(0));
    for (int i = 0; i < 7; i++) begin
      step();
      check("seq_valid", 32'(d_valid), 32'(1));
      check("seq_instr", 32'(d_instr), 32'(exp_words[i]));
      check("seq_pc",    32'(d_pc), 32'(i));
      step();
      if (i < 6) check("seq_gap_valid", 32'(d_valid), 32'(0));
    end
    check("seq_end_halted", 32'(d_halted), 32'(1));
    check("seq_end_pc",     32'(d_pc), 32'(7));
    check("seq_end_valid",  32'(d_valid), 32'(0));

    // Restart from HALTED, then stall at pc=2 (start pulsed mid-stall).
    d_start = 1'b1;
    step();
    d_start = 1'b0;
    check("restart_halted", 32'(d_halted), 32'(0));
    check("restart_pc",     32'(d_pc), 32'(0));
    step(); step(); step(); step();
    d_ready = 1'b0;
    step();
    check("stall_entry_instr", 32'(d_instr), 32'h38);
    check("stall_entry_pc",    32'(d_pc), 32'(2));
    for (int k = 0; k < 5; k++) begin
      d_start = (k == 2);
      step();
      check("stall_instr", 32'(d_instr), 32'h38);
      check("stall_valid", 32'(d_valid), 32'(1));
      check("stall_pc",    32'(d_pc), 32'(2));
    end
    d_start = 1'b0;
    d_ready = 1'b1;
    step();
    check("stall_release_pc",    32'(d_pc), 32'(3));
    check("stall_release_valid", 32'(d_valid), 32'(0));
    step();
    check("after_stall_instr", 32'(d_instr), 32'h17);
    step();
    step();
    check("pre_rst_pc",    32'(d_pc), 32'(4));
    check("pre_rst_instr", 32'(d_instr), 32'h31);
    check("pre_rst_valid", 32'(d_valid), 32'(1));

    // Reset in VALID with ready and start asserted.
    d_rst   = 1'b1;
    d_start = 1'b1;
    step();
    check("midrst_valid",  32'(d_valid), 32'(0));
    check("midrst_pc",     32'(d_pc), 32'(0));
    check("midrst_state",  32'(u_def.state), 32'(IDLE));
    check("midrst_instr",  32'(d_instr), 32'(0));
    check("midrst_halted", 32'(d_halted), 32'(0));
    d_rst   = 1'b0;
    d_start = 1'b0;
    step(); step(); step();
    check("postrst_state", 32'(u_def.state), 32'(IDLE));
    check("postrst_valid", 32'(d_valid), 32'(0));

    // Jump in range and out of range.
    d_start = 1'b1;
    step();
    d_start = 1'b0;
    step(); step(); step();
    check("jmp_src_pc",    32'(d_pc), 32'(1));
    check("jmp_src_instr", 32'(d_instr), 32'h2D);
    d_jump_en   = 1'b1;
    d_jump_addr = 4'd5;
    step();
    d_jump_en = 1'b0;
    check("jmp_pc",    32'(d_pc), 32'(5));
    check("jmp_state", 32'(u_def.state), 32'(FETCH));
    step();
    check("jmp_instr", 32'(d_instr), 32'h07);
    check("jmp_valid", 32'(d_valid), 32'(1));
    d_jump_en   = 1'b1;
    d_jump_addr = 4'd9;
    step();
    d_jump_en = 1'b0;
    check("jmp_oob_halted", 32'(d_halted), 32'(1));
    check("jmp_oob_pc",     32'(d_pc), 32'(9));
    check("jmp_oob_valid",  32'(d_valid), 32'(0));

    // Halt opcode at address 2; a jump on that accept is ignored.
    h_rst   = 1'b0;
    h_start = 1'b1;
    h_ready = 1'b1;
    step();
    h_start = 1'b0;
    step(); step(); step(); step(); step();
    check("hlt_word_instr", 32'(h_instr), 32'hF0);
    check("hlt_word_pc",    32'(h_pc), 32'(2));
    h_jump_en   = 1'b1;
    h_jump_addr = 4'd5;
    step();
    h_jump_en = 1'b0;
    check("hlt_halted", 32'(h_halted), 32'(1));
    check("hlt_pc",     32'(h_pc), 32'(2));
    check("hlt_valid",  32'(h_valid), 32'(0));
    step();
    check("hlt_stay", 32'(h_halted), 32'(1));
    h_start = 1'b1;
    step();
    h_start = 1'b0;
    check("hlt_restart_halted", 32'(h_halted), 32'(0));
    check("hlt_restart_pc",     32'(h_pc), 32'(0));
    step();
    check("hlt_restart_instr", 32'(h_instr), 32'h22);
    check("hlt_restart_valid", 32'(h_valid), 32'(1));

    // Wrap-around over a full 4-word address space.
    w_rst   = 1'b0;
    w_start = 1'b1;
    w_ready = 1'b1;
    step();
    w_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("wrap_pc",     32'(w_pc), 32'(k % 4));
      check("wrap_instr",  32'(w_instr), 32'(exp_words[k % 4]));
      check("wrap_halted", 32'(w_halted), 32'(0));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
